display_scanout: RTL

DISPLAY_SCANOUT -- requirements
Module: display_scanout

---
 rtl/display_scanout.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/display_scanout.sv
// display_scanout
//   Streams one frame of 64-bit display-buffer words out as 8-bit pixels,
//   lowest byte of each word first, with frame/line markers on a
//   valid/ready pixel interface.
//
// Ports
//   clk, reset_n          : single clock; synchronous active-low reset
//   start                 : one-cycle frame request, honoured only when idle
//   busy, done            : busy from the cycle after an accepted start until
//                           done; done is a one-cycle completion pulse
//   read_addr / read_data : combinational read port of the display buffer
//   pixel_data, pixel_valid, pixel_ready : pixel stream
//   pixel_sof/sol/eol/eof : first of frame, first of line, last of line,
//                           last of frame
//   stall_count           : cycles with pixel_valid=1 and pixel_ready=0,
//                           saturating (only with DISPLAY_SCANOUT_STALL_COUNT_EN)
//   dbg_state_o           : current FSM state
//
// Handshake: a pixel transfers on a rising edge where pixel_valid and
// pixel_ready are both high; while pixel_valid is high and pixel_ready is low,
// pixel_data and every marker hold stable.
//
// Optional feature macro: DISPLAY_SCANOUT_STALL_COUNT_EN
module display_scanout #(
   parameter int NUM_WORDS      = 128,
   parameter int WORDS_PER_LINE = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [6:0]  read_addr,
   input  logic [63:0] read_data,
   output logic [7:0]  pixel_data,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        pixel_sof,
   output logic        pixel_sol,
   output logic        pixel_eol,
   output logic        pixel_eof,
`ifdef DISPLAY_SCANOUT_STALL_COUNT_EN
   output logic [15:0] stall_count,
`endif
   output logic [1:0]  dbg_state_o
);

   localparam int             LW        = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam logic [7:0]     LAST_CNT  = 8'(NUM_WORDS);
   localparam logic [LW-1:0]  LAST_LPOS = LW'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [63:0]     shift_q, shift_d;   // held word, current pixel in [7:0]
   logic [2:0]      k_q, k_d;           // pixel index within held word
   logic [7:0]      wcnt_q, wcnt_d;     // next word to load (held word = wcnt-1)
   logic [LW-1:0]   lpos_q, lpos_d;     // held word's position within its line

   logic accept;
   logic last_word;

   assign accept    = (state_q == S_STREAM) && pixel_ready;
   // wcnt is 8 bits so that NUM_WORDS=128 is representable here.
   assign last_word = (wcnt_q == LAST_CNT);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LOAD;
         S_LOAD:   state_d = S_STREAM;
         S_STREAM: if (accept && (k_q == 3'd7) && last_word) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy        = (state_q == S_LOAD) || (state_q == S_STREAM);
      done        = (state_q == S_DONE);
      pixel_valid = (state_q == S_STREAM);
      read_addr   = (state_q == S_STREAM) ? wcnt_q[6:0] : 7'd0;
      pixel_data  = pixel_valid ? shift_q[7:0] : 8'd0;
      pixel_sof   = pixel_valid && (k_q == 3'd0) && (wcnt_q == 8'd1);
      pixel_sol   = pixel_valid && (k_q == 3'd0) && (lpos_q == '0);
      pixel_eol   = pixel_valid && (k_q == 3'd7) && (lpos_q == LAST_LPOS);
      pixel_eof   = pixel_valid && (k_q == 3'd7) && last_word;
   end

   assign dbg_state_o = state_q;

   // Datapath next state. The next word is captured on the same edge that
   // accepts pixel 7 of the current one, so there is no bubble between words.
   always_comb begin
      shift_d = shift_q;
      k_d     = k_q;
      wcnt_d  = wcnt_q;
      lpos_d  = lpos_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               wcnt_d = 8'd0;
               k_d    = 3'd0;
               lpos_d = '0;
            end
         end
         S_LOAD: begin
            shift_d = read_data;
            wcnt_d  = 8'd1;
            k_d     = 3'd0;
            lpos_d  = '0;
         end
         S_STREAM: begin
            if (accept) begin
               if (k_q != 3'd7) begin
                  shift_d = shift_q >> 8;
                  k_d     = k_q + 3'd1;
               end else if (!last_word) begin
                  shift_d = read_data;
                  k_d     = 3'd0;
                  wcnt_d  = wcnt_q + 8'd1;
                  lpos_d  = (lpos_q == LAST_LPOS) ? '0 : lpos_q + LW'(1);
               end else begin
                  k_d = 3'd0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift_q <= '0;
         k_q     <= '0;
         wcnt_q  <= '0;
         lpos_q  <= '0;
      end else begin
         shift_q <= shift_d;
         k_q     <= k_d;
         wcnt_q  <= wcnt_d;
         lpos_q  <= lpos_d;
      end
   end

`ifdef DISPLAY_SCANOUT_STALL_COUNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && start)
         stall_d = 16'd0;
      else if ((state_q == S_STREAM) && !pixel_ready && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) stall_q <= 16'd0;
      else          stall_q <= stall_d;
   end

   assign stall_count = stall_q;
`endif

endmodule
